// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared state encoding and sizing helpers for the SPI master
package spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        HIGH,
        LOW,
        CS_HOLD,
        DONE
    } state_e;

    // A single chip select still needs a 1-bit selector port.
    localparam int CS_SEL_MIN_W = 1;

    function automatic int cs_sel_width(input int ncs);
        return (ncs > 1) ? $clog2(ncs) : CS_SEL_MIN_W;
    endfunction

endpackage

// File: rtl/spi_master_clkdiv.sv
// rtl/spi_master_clkdiv.sv - HALF-cycle phase timer, restarted on every state change
module spi_master_clkdiv #(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic restart_i,
    output logic phase_done_o
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;

    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (restart_i) begin
            cnt_d   = CW'(HALF - 1);
            armed_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign phase_done_o = armed_q && (cnt_q == '0);

endmodule

// File: rtl/spi_master_xfer.sv
// rtl/spi_master_xfer.sv - mode-0 SPI master: one packet per chip-select assertion
module spi_master_xfer
    import spi_master_pkg::*;
#(
    parameter int NBITS = 34,
    parameter int NCS   = 3,
    parameter int HALF  = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NBITS-1:0]               send_msg,
    input  logic [cs_sel_width(NCS)-1:0]   send_cs_sel,
    input  logic                           send_val,
    output logic                           send_rdy,
    output logic [NBITS-1:0]               recv_msg,
    output logic                           recv_val,
    input  logic                           recv_rdy,
    output logic [NCS-1:0]                 spi_cs,
    output logic                           spi_sclk,
    output logic                           spi_mosi,
    input  logic                           spi_miso,
    output logic                           busy
);

    localparam int CSW = cs_sel_width(NCS);
    localparam int BW  = $clog2(NBITS + 1);

    state_e             state_q, state_d;
    logic [NBITS-1:0]   tx_q, tx_d, rx_q, rx_d, recv_msg_q, recv_msg_d;
    logic [CSW-1:0]     sel_q, sel_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic               recv_val_q, recv_val_d;
    logic [NCS-1:0]     cs_q, cs_d;
    logic               sclk_q, sclk_d, mosi_q, mosi_d;
    logic               phase_done, active;

    spi_master_clkdiv #(.HALF(HALF)) u_clkdiv (
        .clk          (clk),
        .reset        (reset),
        .restart_i    (state_d != state_q),
        .phase_done_o (phase_done)
    );

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        sel_d      = sel_q;
        bit_d      = bit_q;
        recv_val_d = recv_val_q;
        recv_msg_d = recv_msg_q;
        case (state_q)
            IDLE: if (send_val) begin
                state_d = CS_SETUP;
                tx_d    = send_msg;
                sel_d   = send_cs_sel;
                rx_d    = '0;
                bit_d   = '0;
            end
            CS_SETUP: if (phase_done) state_d = HIGH;
            HIGH: if (phase_done) begin
                if (bit_q == BW'(NBITS)) begin
                    state_d = CS_HOLD;
                end else begin
                    state_d = LOW;
                    tx_d    = tx_q << 1;
                end
            end
            LOW: if (phase_done) state_d = HIGH;
            CS_HOLD: if (phase_done) begin
                state_d    = DONE;
                recv_val_d = 1'b1;
                recv_msg_d = rx_q;
            end
            DONE: if (recv_rdy) begin
                state_d    = IDLE;
                recv_val_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // miso is captured on the same edge that raises sclk
        if (state_d == HIGH && state_q != HIGH) begin
            rx_d  = {rx_q[NBITS-2:0], spi_miso};
            bit_d = bit_q + 1'b1;
        end

        active = (state_d == CS_SETUP) || (state_d == HIGH) ||
                 (state_d == LOW) || (state_d == CS_HOLD);
        sclk_d = (state_d == HIGH);
        mosi_d = active ? tx_d[NBITS-1] : 1'b0;
        cs_d   = '1;
        for (int i = 0; i < NCS; i++) begin
            if (active && sel_d == CSW'(i)) cs_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_q       <= '0;
            rx_q       <= '0;
            sel_q      <= '0;
            bit_q      <= '0;
            recv_val_q <= 1'b0;
            recv_msg_q <= '0;
            cs_q       <= '1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            sel_q      <= sel_d;
            bit_q      <= bit_d;
            recv_val_q <= recv_val_d;
            recv_msg_q <= recv_msg_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
        end
    end

    assign send_rdy = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign recv_val = recv_val_q;
    assign recv_msg = recv_msg_q;
    assign spi_cs   = cs_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_xfer.sv
// tb/tb_spi_master_xfer.sv - vector table plus random transfers against a packet-level model
module tb_spi_master_xfer;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: NBITS=8, HALF=2
    logic       rst_a, send_val_a, send_rdy_a, recv_val_a, recv_rdy_a;
    logic [7:0] send_msg_a, recv_msg_a;
    logic [1:0] sel_a;
    logic [2:0] cs_a;
    logic       sclk_a, mosi_a, miso_a, busy_a;
    int         miso_mode;

    assign miso_a = (miso_mode == 0) ? mosi_a : (miso_mode == 1);

    spi_master_xfer #(.NBITS(8), .NCS(3), .HALF(2)) dut_a (
        .clk(clk), .reset(rst_a), .send_msg(send_msg_a), .send_cs_sel(sel_a),
        .send_val(send_val_a), .send_rdy(send_rdy_a), .recv_msg(recv_msg_a),
        .recv_val(recv_val_a), .recv_rdy(recv_rdy_a), .spi_cs(cs_a),
        .spi_sclk(sclk_a), .spi_mosi(mosi_a), .spi_miso(miso_a), .busy(busy_a)
    );

    // instance B: NBITS=34, HALF=1, miso from a minion returning word_b
    logic        rst_b, send_val_b, send_rdy_b, recv_val_b, recv_rdy_b;
    logic [33:0] send_msg_b, recv_msg_b, word_b;
    logic [1:0]  sel_b;
    logic [2:0]  cs_b;
    logic        sclk_b, mosi_b, miso_b, busy_b, cs_idle_b;
    int          idx_b;

    assign word_b    = 34'h2_C35A_96E1;
    assign cs_idle_b = &cs_b;
    assign miso_b    = (idx_b < 34) ? word_b[33 - idx_b] : 1'b0;
    always @(posedge sclk_b or posedge cs_idle_b)
        if (cs_idle_b) idx_b <= 0;
        else           idx_b <= idx_b + 1;

    spi_master_xfer #(.NBITS(34), .NCS(3), .HALF(1)) dut_b (
        .clk(clk), .reset(rst_b), .send_msg(send_msg_b), .send_cs_sel(sel_b),
        .send_val(send_val_b), .send_rdy(send_rdy_b), .recv_msg(recv_msg_b),
        .recv_val(recv_val_b), .recv_rdy(recv_rdy_b), .spi_cs(cs_b),
        .spi_sclk(sclk_b), .spi_mosi(mosi_b), .spi_miso(miso_b), .busy(busy_b)
    );

    typedef struct {
        logic [7:0] msg;
        logic [1:0] sel;
        int         mode;       // 0 loopback, 1 miso=1, 2 miso=0
        int         rdy_delay;
        logic       hold;       // keep send_val high for a back-to-back follow-up
        logic [7:0] exp_rx;
    } vec_t;

    int  n_vec, n_err;
    logic prev_hold;
    time  last_rv_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_rx(input logic [7:0] msg, input int mode);
        case (mode)
            0:       return msg;
            1:       return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    // Caller is at a negedge; returns at the negedge after the DONE->IDLE edge.
    task automatic xfer_a(input vec_t v, input string nm);
        logic [7:0] bits;
        logic [2:0] exp_cs;
        logic       prev_sclk;
        int         n, lat, rises, cs_low, cs_bad, stall_bad;
        exp_cs    = (v.sel < 2'd3) ? ~(3'b001 << v.sel) : 3'b111;
        miso_mode = v.mode;
        chk({nm, " send_rdy_idle"}, 64'(send_rdy_a), 64'd1);
        send_msg_a = v.msg;
        sel_a      = v.sel;
        send_val_a = 1'b1;
        recv_rdy_a = (v.rdy_delay == 0);
        @(posedge clk);
        n = 0; lat = 0; rises = 0; cs_low = 0; cs_bad = 0; prev_sclk = 1'b0; bits = '0;
        while (n < 200 && lat == 0) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                if (!v.hold) send_val_a = 1'b0;
                send_msg_a = ~v.msg;
                chk({nm, " busy_after_accept"}, 64'(busy_a), 64'd1);
                if (prev_hold) chk({nm, " b2b_gap"}, 64'(($time - last_rv_t) / 10), 64'd2);
            end
            if (cs_a != 3'b111) begin
                cs_low++;
                if (cs_a != exp_cs) cs_bad++;
            end
            if (sclk_a && !prev_sclk) begin
                bits = {bits[6:0], mosi_a};
                rises++;
            end
            prev_sclk = sclk_a;
            if (recv_val_a) lat = n;
        end
        last_rv_t = $time;
        chk({nm, " latency"}, 64'(lat), 64'd35);
        chk({nm, " cs_low_cycles"}, 64'(cs_low), (v.sel < 2'd3) ? 64'd34 : 64'd0);
        chk({nm, " cs_pattern"}, 64'(cs_bad), 64'd0);
        chk({nm, " sclk_rises"}, 64'(rises), 64'd8);
        chk({nm, " mosi_bits"}, 64'(bits), 64'(v.msg));
        chk({nm, " recv_msg"}, 64'(recv_msg_a), 64'(v.exp_rx));
        stall_bad = 0;
        for (int k = 0; k < v.rdy_delay; k++) begin
            @(negedge clk);
            if (recv_val_a !== 1'b1 || recv_msg_a !== v.exp_rx || send_rdy_a !== 1'b0) stall_bad++;
        end
        chk({nm, " stall_hold"}, 64'(stall_bad), 64'd0);
        recv_rdy_a = 1'b1;
        @(negedge clk);
        chk({nm, " released"}, 64'({send_rdy_a, recv_val_a, busy_a, cs_a}), 64'({3'b100, 3'b111}));
        prev_hold = v.hold;
    endtask

    vec_t tbl[$];

    initial begin
        vec_t v;
        logic [63:0] r64;
        logic [33:0] bits_b;
        logic        prev;
        int          n, lat, rises, last, per_bad;

        n_vec = 0; n_err = 0; prev_hold = 1'b0; last_rv_t = 0; miso_mode = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        send_val_a = 0; send_msg_a = '0; sel_a = '0; recv_rdy_a = 0;
        send_val_b = 0; send_msg_b = '0; sel_b = 2'd2; recv_rdy_b = 0;

        tbl.push_back('{8'hA5, 2'd1, 0, 0, 1'b0, ref_rx(8'hA5, 0)});
        tbl.push_back('{8'h00, 2'd1, 1, 5, 1'b0, ref_rx(8'h00, 1)});
        tbl.push_back('{8'h3C, 2'd0, 0, 0, 1'b1, ref_rx(8'h3C, 0)});
        tbl.push_back('{8'hC3, 2'd0, 0, 0, 1'b0, ref_rx(8'hC3, 0)});
        tbl.push_back('{8'h5A, 2'd3, 2, 1, 1'b0, ref_rx(8'h5A, 2)});
        tbl.push_back('{8'h81, 2'd2, 0, 2, 1'b0, ref_rx(8'h81, 0)});
        for (int i = 0; i < 16; i++) begin
            v.msg       = 8'($urandom);
            v.sel       = 2'($urandom_range(0, 3));
            v.mode      = int'($urandom_range(0, 2));
            v.rdy_delay = int'($urandom_range(0, 3));
            v.hold      = 1'b0;
            v.exp_rx    = ref_rx(v.msg, v.mode);
            tbl.push_back(v);
        end

        @(negedge clk);
        chk("reset_state_a", 64'({send_rdy_a, busy_a, cs_a, sclk_a, mosi_a, recv_val_a, recv_msg_a}),
            64'({1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 8'h00}));
        chk("reset_state_b", 64'({send_rdy_b, busy_b, cs_b, sclk_b, recv_val_b}), 64'({1'b1, 1'b0, 3'b111, 2'b00}));
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) xfer_a(tbl[i], $sformatf("v%0d", i));

        // reset during bit 4
        miso_mode = 0; send_msg_a = 8'h77; sel_a = 2'd0; send_val_a = 1'b1; recv_rdy_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        send_val_a = 1'b0;
        n = 0; rises = 0; prev = 1'b0;
        while (n < 100 && rises < 4) begin
            if (sclk_a && !prev) rises++;
            prev = sclk_a;
            if (rises < 4) begin @(negedge clk); n++; end
        end
        chk("rst_reached_bit4", 64'(rises), 64'd4);
        rst_a = 1'b1;
        #1;
        chk("rst_async_outputs", 64'({cs_a, sclk_a, recv_val_a, send_rdy_a}), 64'({3'b111, 1'b0, 1'b0, 1'b1}));
        @(negedge clk);
        rst_a = 1'b0;
        prev_hold = 1'b0;
        @(negedge clk);
        xfer_a('{8'h5A, 2'd1, 0, 0, 1'b0, ref_rx(8'h5A, 0)}, "post_reset");

        // long packet, HALF=1
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            r64 = {$urandom, $urandom};
            send_msg_b = r64[33:0]; sel_b = 2'd2; send_val_b = 1'b1; recv_rdy_b = 1'b1;
            @(posedge clk);
            n = 0; lat = 0; rises = 0; last = 0; per_bad = 0; prev = 1'b0; bits_b = '0;
            while (n < 300 && lat == 0) begin
                @(negedge clk);
                n++;
                if (n == 1) send_val_b = 1'b0;
                if (sclk_b && !prev) begin
                    if (rises > 0 && n - last != 2) per_bad++;
                    last = n;
                    rises++;
                    bits_b = {bits_b[32:0], mosi_b};
                end
                prev = sclk_b;
                if (recv_val_b) lat = n;
            end
            chk($sformatf("b%0d latency", r), 64'(lat), 64'd70);
            chk($sformatf("b%0d sclk_rises", r), 64'(rises), 64'd34);
            chk($sformatf("b%0d sclk_period", r), 64'(per_bad), 64'd0);
            chk($sformatf("b%0d mosi_bits", r), 64'(bits_b), 64'(r64[33:0]));
            chk($sformatf("b%0d recv_msg", r), 64'(recv_msg_b), 64'(word_b));
            @(negedge clk);
            chk($sformatf("b%0d released", r), 64'({recv_val_b, send_rdy_b}), 64'(2'b01));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_master_xfer.md
Name: spi_master_xfer

Overview:
- SPI initiator (mode 0: CPOL=0, CPHA=0) that drives the minion-side SPI pins of the FFT/SPI interconnect.
- Takes a full-width packet on a val/rdy send stream and shifts it out MSB-first on mosi, selecting one of NCS chip selects.
- Captures the same number of miso bits and returns them on a val/rdy recv stream.
- Used as the on-chip or testbench-side master for the minion ports of the FFT SPI interconnect.

Parameters:
- NBITS, 34, packet width in bits (bits shifted per CS assertion).
- NCS, 3, number of chip-select outputs.
- HALF, 2, sclk half-period in clk cycles (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- send_msg  in  NBITS  packet to transmit.
- send_cs_sel  in  $clog2(NCS) (min 1)  index of chip select to assert.
- send_val  in  1  send packet valid.
- send_rdy  out  1  master ready to accept a packet.
- recv_msg  out  NBITS  packet captured from miso.
- recv_val  out  1  received packet valid.
- recv_rdy  in  1  consumer ready.
- spi_cs  out  NCS  chip selects, active low.
- spi_sclk  out  1  serial clock.
- spi_mosi  out  1  master-out data.
- spi_miso  in  1  master-in data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE; spi_cs all 1; spi_sclk=0; spi_mosi=0; recv_val=0; recv_msg=0; shift/bit/div counters 0. Resulting outputs: send_rdy=1, busy=0.
- send_rdy = (state==IDLE), combinational from state. Accept on the clk edge where send_val & send_rdy:
  - latch send_msg into tx shift register and send_cs_sel into the cs register;
  - go to CS_SETUP.
- CS_SETUP (HALF cycles):
  - selected spi_cs bit = 0, all others 1; sclk=0; mosi = tx[NBITS-1].
  - If send_cs_sel ≥ NCS, no cs bit asserts, but the transfer still runs in full.
- HIGH (HALF cycles):
  - sclk=1.
  - On the clk edge entering HIGH (sclk rising), shift spi_miso into rx register LSB (rx <= {rx[NBITS-2:0], miso}).
- LOW (HALF cycles):
  - sclk=0.
  - On entering LOW, tx shifts left and mosi presents the next bit.
  - bit counter increments per HIGH phase.
- Transitions:
  - After the NBITS-th HIGH phase, go to CS_HOLD instead of LOW.
  - CS_HOLD (HALF cycles): sclk=0, cs still asserted. On exit, cs all 1; recv_msg <= rx; recv_val <= 1; go to DONE.
- DONE:
  - Hold recv_val=1 and recv_msg stable until recv_rdy=1, then recv_val=0 on that edge and go to IDLE.
  - If recv_rdy is already 1 when DONE is entered, exactly one cycle in DONE.
- Timing:
  - cs is low for exactly HALF*(2*NBITS+1) cycles; exactly NBITS sclk rising edges per transfer.
  - Accept-to-recv_val latency = HALF*(2*NBITS+1) + 1 cycles.
  - Minimum cs-high gap between back-to-back transfers: 2 cycles (DONE + IDLE).
- send_val while busy is ignored (send_rdy=0); send_msg changes after accept do not affect the transfer.
- Reset mid-transfer: cs released and sclk=0 immediately (async); partial rx discarded; no recv_val.
- spi_mosi, spi_sclk and spi_cs are driven from flops (glitch-free); spi_miso is used unsynchronised (same clock domain as the minion).

Decomposition:
- Shared package spi_master_pkg:
  - state enum {IDLE, CS_SETUP, HIGH, LOW, CS_HOLD, DONE};
  - localparam for the cs_sel width rule.
- One sub-module spi_master_clkdiv: HALF-cycle down-counter producing a one-cycle phase_done pulse, restartable on state change.

Test Plan:
- NBITS=8, HALF=2, miso looped to mosi; send 0xA5 on cs_sel=1:
  - spi_cs=3'b101 for exactly 34 cycles; 8 sclk rising edges;
  - recv_msg=0xA5 at cycle 35 after accept.
- NBITS=8, miso tied 1; send 0x00, recv_rdy held 0 for 5 cycles:
  - recv_val stays 1, recv_msg=0xFF stable;
  - send_rdy=0 until the cycle after recv_rdy=1.
- Back-to-back 0x3C then 0xC3 with send_val held high:
  - second accept 2 cycles after the first recv_val when recv_rdy=1;
  - mosi bit sequences 00111100 then 11000011 sampled on sclk rising edges.
- Assert reset during bit 4 of a transfer:
  - same cycle: spi_cs=3'b111, sclk=0, recv_val=0;
  - after release: send_rdy=1 and a fresh 0x5A transfer completes correctly.
- send_cs_sel=3 with NCS=3:
  - all cs stay 1; transfer still produces recv_val after 35 cycles.
- HALF=1, NBITS=34, random packet, miso driven by a model minion returning a fixed 34-bit word:
  - recv_msg equals the model word; sclk period = 2 cycles.
